// File: rtl/usb_stat_pkt_tx.sv
//==============================================================================
// Module      : usb_stat_pkt_tx
// Description : Transmit framer for FTDI link readback/status frames
//               (sync, addr, reserved, len, hdr check, data, data check).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module usb_stat_pkt_tx #(
    parameter logic [7:0] SYNC_B0 = 8'h5E,
    parameter logic [7:0] SYNC_B1 = 8'h4D,
    parameter int         MAX_LEN = 8
) (
    input  logic                 clk_ftdi,
    input  logic                 n_rst,
    input  logic                 tx_req,
    input  logic [7:0]           tx_addr,
    input  logic [3:0]           tx_len,
    input  logic [8*MAX_LEN-1:0] tx_data,
    output logic [7:0]           q,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_err
);

    localparam int         C_DW      = 8 * MAX_LEN;
    localparam logic [3:0] C_MAX_LEN = 4'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SYNC0 = 4'd1,
        S_SYNC1 = 4'd2,
        S_ADDR  = 4'd3,
        S_RSV   = 4'd4,
        S_LEN   = 4'd5,
        S_HCHK  = 4'd6,
        S_DATA  = 4'd7,
        S_DCHK  = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_addr;
    logic [3:0]      r_len;
    logic [C_DW-1:0] r_data;
    logic [3:0]      r_cnt;
    logic [7:0]      r_chk;
    logic            r_err;

    logic            w_len_ok;
    logic            w_start;
    logic            w_hs;
    logic            w_last_data;
    logic [7:0]      w_data_byte;

    assign w_len_ok    = (tx_len != 4'd0) && (tx_len <= C_MAX_LEN);
    assign w_start     = (r_state == S_IDLE) && tx_req && w_len_ok;
    assign w_hs        = q_valid && q_ready;
    assign w_last_data = (r_cnt == (r_len - 4'd1));
    assign w_data_byte = r_data[C_DW-1 -: 8];

    assign q_valid = (r_state != S_IDLE);
    assign tx_busy = (r_state != S_IDLE);
    // Combinational so the pulse lands in the same cycle the check byte is taken.
    assign tx_done = (r_state == S_DCHK) && q_ready;
    assign tx_err  = r_err;

    always_ff @(posedge clk_ftdi or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start)              w_next_state = S_SYNC0;
            S_SYNC0: if (w_hs)                 w_next_state = S_SYNC1;
            S_SYNC1: if (w_hs)                 w_next_state = S_ADDR;
            S_ADDR:  if (w_hs)                 w_next_state = S_RSV;
            S_RSV:   if (w_hs)                 w_next_state = S_LEN;
            S_LEN:   if (w_hs)                 w_next_state = S_HCHK;
            S_HCHK:  if (w_hs)                 w_next_state = S_DATA;
            S_DATA:  if (w_hs && w_last_data)  w_next_state = S_DCHK;
            S_DCHK:  if (w_hs)                 w_next_state = S_IDLE;
            default:                           w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        q = 8'h00;
        case (r_state)
            S_SYNC0: q = SYNC_B0;
            S_SYNC1: q = SYNC_B1;
            S_ADDR:  q = r_addr;
            S_RSV:   q = 8'h00;
            S_LEN:   q = {4'h0, r_len};
            S_HCHK:  q = r_addr ^ {4'h0, r_len};
            S_DATA:  q = w_data_byte;
            S_DCHK:  q = r_chk;
            default: q = 8'h00;
        endcase
    end

    // Payload is captured at request time; the shift register presents the next byte at the MSB.
    always_ff @(posedge clk_ftdi or negedge n_rst) begin
        if (!n_rst) begin
            r_addr <= 8'h00;
            r_len  <= 4'h0;
            r_data <= '0;
            r_cnt  <= 4'h0;
            r_chk  <= 8'h00;
            r_err  <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && tx_req && !w_len_ok;
            if (w_start) begin
                r_addr <= tx_addr;
                r_len  <= tx_len;
                r_data <= tx_data;
                r_cnt  <= 4'h0;
                r_chk  <= 8'h00;
            end else if ((r_state == S_DATA) && w_hs) begin
                r_data <= r_data << 8;
                r_cnt  <= r_cnt + 4'd1;
                r_chk  <= r_chk ^ w_data_byte;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_stat_pkt_tx.sv
//==============================================================================
// Module      : tb_usb_stat_pkt_tx
// Description : Scoreboard bench for usb_stat_pkt_tx frame output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_usb_stat_pkt_tx;

    logic        clk;
    logic        n_rst;
    logic        tx_req;
    logic [7:0]  tx_addr;
    logic [3:0]  tx_len;
    logic [63:0] tx_data;
    logic [7:0]  q;
    logic        q_valid;
    logic        q_ready;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [8:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_q = 8'h00;

    usb_stat_pkt_tx #(
        .SYNC_B0 (8'h5E),
        .SYNC_B1 (8'h4D),
        .MAX_LEN (8)
    ) u_dut (
        .clk_ftdi (clk),
        .n_rst    (n_rst),
        .tx_req   (tx_req),
        .tx_addr  (tx_addr),
        .tx_len   (tx_len),
        .tx_data  (tx_data),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bytes are given MSB-first; the final byte is flagged as the one that must carry tx_done.
    task automatic push_frame(input int n, input logic [127:0] v);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = v[8*(n-1-i) +: 8];
            exp_q.push_back({(i == n - 1), b});
        end
    endtask

    task automatic request(input logic [7:0] a, input logic [3:0] l, input logic [63:0] d);
        tx_addr = a;
        tx_len  = l;
        tx_data = d;
        tx_req  = 1'b1;
        tick();
        tx_req  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > start) break;
            tick();
        end
        chk({name, "_done_seen"}, 32'(done_cnt > start), 32'd1);
    endtask

    // Monitor: pops the scoreboard on every handshake, and checks hold during stalls.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!n_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(q_valid), 32'd1);
                chk("stall_hold_q", 32'(q), 32'(prev_q));
            end
            if (q_valid && q_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", q);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", 32'(q), 32'(e[7:0]));
                    chk("stream_done", 32'(tx_done), 32'(e[8]));
                end
                if (tx_done) done_cnt++;
            end else if (tx_done) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_done actual=1 expected=0");
            end
            prev_stall = q_valid && !q_ready;
            prev_q     = q;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int d0;
        n_rst   = 1'b0;
        tx_req  = 1'b0;
        tx_addr = 8'h00;
        tx_len  = 4'h0;
        tx_data = 64'h0;
        q_ready = 1'b1;
        repeat (3) tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_valid", 32'(q_valid), 32'h0);
        chk("rst_busy", 32'(tx_busy), 32'h0);
        chk("rst_done", 32'(tx_done), 32'h0);
        chk("rst_err", 32'(tx_err), 32'h0);
        n_rst = 1'b1;
        tick();

        // Case 1: short frame, one-cycle request latency
        push_frame(9, 72'h5E4D0800020A030506);
        request(8'h08, 4'd2, {8'h03, 8'h05, 48'h0});
        chk("c1_lat_valid", 32'(q_valid), 32'd1);
        chk("c1_lat_q", 32'(q), 32'h5E);
        wait_done("c1", 40);
        chk("c1_idle_valid", 32'(q_valid), 32'd0);
        chk("c1_idle_busy", 32'(tx_busy), 32'd0);

        // Case 2: full-length frame
        push_frame(15, 120'h5E4D00000808A1A2A3A4A5A6A7A808);
        request(8'h00, 4'd8, 64'hA1A2A3A4A5A6A7A8);
        wait_done("c2", 40);
        chk("c2_qempty", 32'(exp_q.size()), 32'd0);

        // Case 3: sink stalls three cycles on the LEN byte
        push_frame(9, 72'h5E4D0800020A030506);
        request(8'h08, 4'd2, {8'h03, 8'h05, 48'h0});
        repeat (4) tick();
        chk("c3_len_shown", 32'(q), 32'h02);
        q_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("c3_stall_q", 32'(q), 32'h02);
        end
        q_ready = 1'b1;
        wait_done("c3", 40);

        // Case 4: illegal lengths rejected
        for (int k = 0; k < 2; k++) begin
            request(8'h33, (k == 0) ? 4'd0 : 4'd9, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("c4_err_pulse", 32'(tx_err), 32'd1);
            chk("c4_err_valid", 32'(q_valid), 32'd0);
            chk("c4_err_busy", 32'(tx_busy), 32'd0);
            tick();
            chk("c4_err_clear", 32'(tx_err), 32'd0);
            chk("c4_err_valid2", 32'(q_valid), 32'd0);
        end

        // Case 5: reset during DATA abandons the frame
        push_frame(15, 120'h5E4D00000808A1A2A3A4A5A6A7A808);
        request(8'h00, 4'd8, 64'hA1A2A3A4A5A6A7A8);
        repeat (8) tick();
        chk("c5_pre_rst_q", 32'(q), 32'hA3);
        d0 = done_cnt;
        n_rst = 1'b0;
        #1;
        chk("c5_rst_valid", 32'(q_valid), 32'd0);
        chk("c5_rst_busy", 32'(tx_busy), 32'd0);
        chk("c5_rst_q", 32'(q), 32'h0);
        exp_q.delete();
        tick();
        n_rst = 1'b1;
        tick();
        chk("c5_no_done", 32'(done_cnt), 32'(d0));
        chk("c5_idle_valid", 32'(q_valid), 32'd0);
        push_frame(15, 120'h5E4D00000808A1A2A3A4A5A6A7A808);
        request(8'h00, 4'd8, 64'hA1A2A3A4A5A6A7A8);
        wait_done("c5_retry", 40);

        // Case 6: request held high; mid-frame field changes only affect the next frame
        push_frame(9, 72'h5E4D0800020A030506);
        push_frame(8, 64'h5E4D10000111_7F7F);
        d0 = done_cnt;
        tx_addr = 8'h08;
        tx_len  = 4'd2;
        tx_data = {8'h03, 8'h05, 48'h0};
        tx_req  = 1'b1;
        tick();
        tx_addr = 8'h10;
        tx_len  = 4'd1;
        tx_data = {8'h7F, 56'h0};
        repeat (9) tick();
        chk("c6_first_done", 32'(done_cnt), 32'(d0 + 1));
        chk("c6_gap_idle", 32'(q_valid), 32'd0);
        tick();
        chk("c6_b2b_valid", 32'(q_valid), 32'd1);
        chk("c6_b2b_sync", 32'(q), 32'h5E);
        tx_req = 1'b0;
        wait_done("c6_second", 40);
        repeat (3) tick();
        chk("c6_end_busy", 32'(tx_busy), 32'd0);
        chk("c6_total_done", 32'(done_cnt), 32'(d0 + 2));

        chk("final_qempty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
